// File: rtl/ame_sobel_grad_if.sv
// Line-stream / result bundle for the AME Sobel gradient engine.
// master drives lines in, slave is the gradient engine.
interface ame_sobel_grad_if #(
  parameter int BLK_SIZE       = 4,
  parameter int PIX_BITS       = 8,
  parameter int COMP_DATA_BITS = 10
);
  logic                                       comp_init_i;
  logic                                       line_valid_i;
  logic [1:0]                                 mode_i;
  logic [(BLK_SIZE+2)*PIX_BITS-1:0]           line_data_i;
  logic                                       comp_done_o;
  logic [BLK_SIZE*BLK_SIZE*COMP_DATA_BITS-1:0] comp_data_o;

  modport master (
    output comp_init_i,
    output line_valid_i,
    output mode_i,
    output line_data_i,
    input  comp_done_o,
    input  comp_data_o
  );

  modport slave (
    input  comp_init_i,
    input  line_valid_i,
    input  mode_i,
    input  line_data_i,
    output comp_done_o,
    output comp_data_o
  );
endinterface

// File: rtl/ame_sobel_grad.sv
// AME Sobel gradient engine: 3-line window over N+2 lines -> NxN |grad|.
// AME_SOBEL_MAG_EN: modes 2/3 give |G0|+|G1|, else they alias mode 0.
module ame_sobel_grad #(
  parameter int BLK_SIZE       = 4,
  parameter int PIX_BITS       = 8,
  parameter int COMP_DATA_BITS = 10
) (
  input  logic            clk_i,
  input  logic            rst_i,
  ame_sobel_grad_if.slave bus
);
  localparam int N  = BLK_SIZE;
  localparam int L  = N + 2;
  localparam int C  = COMP_DATA_BITS;
  localparam int CW = $clog2(L);
  localparam int GW = PIX_BITS + 3;
  localparam int SW = ((GW > C) ? GW : C) + 1;

  localparam logic [SW-1:0] SAT  = {{(SW-C){1'b0}}, {C{1'b1}}};
  localparam logic [CW-1:0] LAST = CW'(N + 1);

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    CALC
  } state_e;

  typedef logic [L-1:0][PIX_BITS-1:0] line_t;
  typedef logic [N-1:0][C-1:0]        row_t;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [1:0]      mode_q, mode_d;
  line_t           a_q, b_q, c;
  logic            done_q, done_d;
  row_t [N-1:0]    data_q;
  row_t            row_val;
  logic            acc, init;
  logic            wr_en, shift;

  logic [N-1:0][GW-1:0] g0, g1;
  logic [N-1:0][SW-1:0] m0, m1, sel;

  assign acc  = bus.line_valid_i;
  assign init = acc & bus.comp_init_i;
  assign c    = bus.line_data_i;

  function automatic logic [GW-1:0] tap(
    input logic [PIX_BITS-1:0] x,
    input logic [PIX_BITS-1:0] y,
    input logic [PIX_BITS-1:0] z
  );
    return {3'b000, x} + {2'b00, y, 1'b0} + {3'b000, z};
  endfunction

  function automatic logic [SW-1:0] mag(input logic [GW-1:0] g);
    logic [GW-1:0] a;
    a = g[GW-1] ? (~g + 1'b1) : g;
    return {{(SW-GW){1'b0}}, a};
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      mode_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mode_q  <= mode_d;
    end
  end

  // A restart wins over whatever the current block is doing.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mode_d  = mode_q;
    if (init) begin
      state_d = FILL;
      cnt_d   = CW'(1);
      mode_d  = bus.mode_i;
    end else if (acc) begin
      unique case (state_q)
        FILL: begin
          state_d = CALC;
          cnt_d   = CW'(2);
        end
        CALC: begin
          if (cnt_q == LAST) begin
            state_d = IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    wr_en  = acc & ~bus.comp_init_i & (state_q == CALC);
    shift  = init | (acc & (state_q != IDLE));
    done_d = wr_en & (cnt_q == LAST);
  end

  always_comb begin
    g0      = '0;
    g1      = '0;
    m0      = '0;
    m1      = '0;
    sel     = '0;
    row_val = '0;
    for (int j = 0; j < N; j++) begin
      g0[j] = tap(c[j], c[j+1], c[j+2])
            - tap(a_q[j], a_q[j+1], a_q[j+2]);
      g1[j] = tap(a_q[j+2], b_q[j+2], c[j+2])
            - tap(a_q[j], b_q[j], c[j]);
      m0[j] = mag(g0[j]);
      m1[j] = mag(g1[j]);
`ifdef AME_SOBEL_MAG_EN
      unique case (1'b1)
        (mode_q == 2'd1): sel[j] = m1[j];
        mode_q[1]:        sel[j] = m0[j] + m1[j];
        default:          sel[j] = m0[j];
      endcase
`else
      unique case (1'b1)
        (mode_q == 2'd1): sel[j] = m1[j];
        default:          sel[j] = m0[j];
      endcase
`endif
      row_val[j] = (sel[j] > SAT) ? SAT[C-1:0]
                                  : sel[j][C-1:0];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_q    <= '0;
      b_q    <= '0;
      done_q <= 1'b0;
      data_q <= '0;
    end else begin
      done_q <= done_d;
      if (shift) begin
        a_q <= b_q;
        b_q <= c;
      end
      for (int r = 0; r < N; r++) begin
        if (wr_en && (cnt_q == CW'(r + 2)))
          data_q[r] <= row_val;
      end
    end
  end

  assign bus.comp_done_o = done_q;
  assign bus.comp_data_o = data_q;

endmodule

// File: doc/ame_sobel_grad.md
Name: ame_sobel_grad

Overview:
- Parametrised Sobel gradient engine for the AME (adaptive motion estimation) edge path; generalises the fixed 6-pixel-line / 4x4-result Sobel filter.
- Streams BLK_SIZE+2 line vectors of BLK_SIZE+2 pixels each through a 3-line window and produces a BLK_SIZE x BLK_SIZE array of absolute gradients.
- Gradient direction is selectable per block, input lines may have gaps, and a block can be restarted mid-stream.
- Sits between the line memories and the AME cost stage.

Parameters:
- BLK_SIZE, 4, output block edge N; input line holds N+2 pixels; N+2 lines per block
- PIX_BITS, 8, unsigned pixel width
- COMP_DATA_BITS, 10, unsigned result width; results saturate at 2^COMP_DATA_BITS-1

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- comp_init_i  in  1  first line of a new block; honoured only together with line_valid_i
- line_valid_i  in  1  line_data_i valid this cycle
- mode_i  in  2  gradient mode, sampled on accepted comp_init_i
- line_data_i  in  (BLK_SIZE+2)*PIX_BITS  packed pixels [0..N+1]
- comp_done_o  out  1  one-cycle pulse when all N rows are written
- comp_data_o  out  BLK_SIZE*BLK_SIZE*COMP_DATA_BITS  packed [row][col] results

Behaviour:
- Reset (clk_i and rst_i only, async high): state IDLE, line counter 0, window lines 0, mode 0, comp_done_o 0, all comp_data_o 0.
- Accept: a line is accepted on a rising edge with line_valid_i=1. Cycles with line_valid_i=0 hold all state.
- States:
  - IDLE: accepted line with comp_init_i=1 -> FILL, counter=1. Accepted line with comp_init_i=0 is ignored.
  - FILL: counter 1; accepted line -> CALC, counter=2.
  - CALC: counter k in 2..N+1. Each accepted line writes row r=k-2. At k=N+1 -> IDLE.
- Restart: comp_init_i=1 with line_valid_i=1 in any state restarts the block. That line becomes line 0, mode is resampled, and the previous block is aborted with no comp_done_o.
- Window: lines a (k-2, reg), b (k-1, reg), c (k, current input). For column j in 0..N-1, using pixels j, j+1, j+2:
  - G0 (across lines) = (c[j]+2c[j+1]+c[j+2]) - (a[j]+2a[j+1]+a[j+2])
  - G1 (along line) = (a[j+2]+2b[j+2]+c[j+2]) - (a[j]+2b[j]+c[j])
  - Signed intermediates are PIX_BITS+3 bits; no overflow is permitted.
- Modes:
  - 0 -> min(|G0|, SAT)
  - 1 -> min(|G1|, SAT)
  - 2/3 -> see Optional Feature
  - SAT = 2^COMP_DATA_BITS-1
- Latency: row r is registered into comp_data_o[r] on the edge accepting line r+2, so it is visible the next cycle.
- comp_done_o: registered on the edge accepting line N+1; high exactly one cycle, coincident with the last row becoming visible.
- Rows not yet rewritten keep the previous block's values. comp_data_o is not cleared on init.
- Back-to-back blocks: a line carrying comp_init_i in the cycle comp_done_o is high is legal and is accepted as line 0 of the next block.

Optional Feature:
- Macro: AME_SOBEL_MAG_EN
- Defined: mode 2 and mode 3 output min(|G0|+|G1|, SAT); both gradients are computed in parallel.
- Undefined: G1 magnitude-sum logic is not built for mode 2; modes 2 and 3 behave as mode 0.

Test Plan:
- Flat block (N=4, P=8, C=10): all pixels 100, six consecutive lines, mode 0 -> all 16 results 0. comp_done_o high only in the cycle after line 5; comp_data_o[0] visible the cycle after line 2.
- Vertical ramp: line k all pixels 10*k. Mode 0 -> all results 80; mode 1 -> all 0.
- Horizontal ramp: pixel i = 30*i in every line. Mode 1 -> all results 240; mode 0 -> 0. With AME_SOBEL_MAG_EN and pixel = 30*i + 10*k, mode 2 -> all 320.
- Saturation (C=8): lines 0-1 all 0, lines 2-5 all 255, mode 0 -> rows 0 and 1 all 255 (raw 1020), rows 2 and 3 all 0.
- Gaps and restart:
  - Two idle cycles inserted after line 2 -> identical results; comp_done_o delayed by 2 cycles.
  - comp_init_i reasserted on line 3 -> no done for the aborted block; done follows line 5 of the new block; results match the new data only.
- Reset mid-CALC: rst_i pulsed after line 3 -> comp_data_o all 0, comp_done_o 0. Subsequent lines without comp_init_i are ignored (no done, data stays 0).
